inv_shift_rows_seq: RTL and testbench
=====================================

INV_SHIFT_ROWS_SEQ -- requirements
Module: inv_shift_rows_seq

Interface
REQ-001 Parameter: IN_MSB_FIRST, default 1, 1 = first accepted byte is state byte 0 (out_state[127:120]); 0 = first accepted byte is byte 15 (out_state[7:0]).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous abort; discards any partial or held block.
REQ-005 in_valid  input  1  in_byte carries a valid state byte.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 in_byte  input  8  state byte; bytes arrive column-major, s[r+4c].
REQ-008 out_valid  output  1  out_state holds a complete transformed block.
REQ-009 out_ready  input  1  consumer accepts out_state.
REQ-010 out_state  output  128  transformed state, byte k at bits [127-8k -: 8].

Function
REQ-011 Transform SHALL be AES InvShiftRows: out[r+4c] = in[r+4*((c-r) mod 4)], r,c in 0..3; row r rotated right by r bytes.
REQ-012 FSM states: LOAD, HOLD.
REQ-013 LOAD: in_ready=1, out_valid=0; each in_valid cycle writes in_byte to slot cnt and increments 4-bit cnt.
REQ-014 LOAD->HOLD when a byte is accepted with cnt=15; cnt wraps to 0.
REQ-015 HOLD: in_ready=0, out_valid=1, out_state stable until handshake.
REQ-016 HOLD->LOAD on out_valid&out_ready; no byte accepted in the same cycle.
REQ-017 Latency: byte 15 accepted at edge N -> out_valid=1 from cycle N+1.
REQ-018 Throughput: one block per 17 cycles with in_valid and out_ready held high.
REQ-019 in_valid low in LOAD: cnt and buffer unchanged; gaps of any length allowed.
REQ-020 out_state SHALL be registered, not combinational from in_byte.
REQ-021 flush=1: next state LOAD, cnt=0, out_valid=0; flush overrides every other event, including a simultaneous byte-15 accept or output handshake.
REQ-022 out_state content while out_valid=0 is don't-care.

Reset
REQ-023 rst_n low: state LOAD, cnt=0, out_valid=0, in_ready=1 after reset, buffer cleared to 0.
REQ-024 Reset mid-load or during HOLD discards the block; no partial output ever emitted.

Configuration
REQ-025 Macro FWD_MODE_EN: when defined, adds input port mode (1 bit, sampled with byte 0 of each block); mode=1 selects forward ShiftRows out[r+4c]=in[r+4*((c+r) mod 4)], mode=0 inverse.
REQ-026 Without FWD_MODE_EN: no mode port, inverse only, no forward logic synthesised.

Structure
REQ-027 Shared package aes_pkg: AES_NB=4, AES_STATE_BYTES=16, typedef aes_state_t (128 bit), typedef aes_byte_t (8 bit), byte-index function.
REQ-028 One sub-module inv_shift_map: purely combinational 128-bit permutation (mode input under FWD_MODE_EN); FSM, counter, buffer live in inv_shift_rows_seq.

Verification
REQ-029 Bytes 00..0f, IN_MSB_FIRST=1, out_ready=1 -> out_state=000d0a07_04010e0b_0805020f_0c090603 one cycle after byte 0f accepted.
REQ-030 Forward output 00050a0f_04090e03_080d0207_0c01060b fed byte-wise -> out_state=00010203_04050607_08090a0b_0c0d0e0f (round trip).
REQ-031 out_ready=0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0, out_state stable, no byte consumed; release -> next block loads from byte 0.
REQ-032 flush after 7 bytes, then bytes 00..0f -> single output equal to REQ-029 value; flush coincident with byte 15 -> no output.
REQ-033 rst_n low asynchronously mid-block (cnt=9) and in HOLD -> out_valid=0 immediately, in_ready=1 after release, next full block correct.
REQ-034 FWD_MODE_EN build, mode=1, bytes 00..0f -> out_state=00050a0f_04090e03_080d0207_0c01060b.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES state types, FSM encoding and byte-index helper for the ShiftRows datapath.
package aes_pkg;

  localparam int AES_NB          = 4;
  localparam int AES_STATE_BYTES = 16;

  typedef logic [8*AES_STATE_BYTES-1:0] aes_state_t;
  typedef logic [7:0]                   aes_byte_t;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_HOLD = 1'b1
  } isr_state_e;

  // Column-major state byte index s[r + 4c]; byte k sits at bits [127-8k -: 8].
  function automatic int aes_byte_idx(input int r, input int c);
    return r + AES_NB * c;
  endfunction

endpackage

// File: rtl/inv_shift_map.sv
// Combinational AES InvShiftRows permutation; zero latency, no flow control.
// With FWD_MODE_EN defined, mode_i=1 selects forward ShiftRows instead.
module inv_shift_map
  import aes_pkg::*;
(
`ifdef FWD_MODE_EN
  input  logic       mode_i,
`endif
  input  aes_state_t state_i,
  output aes_state_t state_o
);

  for (genvar r = 0; r < AES_NB; r++) begin : g_row
    for (genvar c = 0; c < AES_NB; c++) begin : g_col
      localparam int DST     = aes_byte_idx(r, c);
      localparam int INV_SRC = aes_byte_idx(r, (c - r + AES_NB) % AES_NB);
`ifdef FWD_MODE_EN
      localparam int FWD_SRC = aes_byte_idx(r, (c + r) % AES_NB);
      assign state_o[127-8*DST -: 8] = mode_i ? state_i[127-8*FWD_SRC -: 8]
                                              : state_i[127-8*INV_SRC -: 8];
`else
      assign state_o[127-8*DST -: 8] = state_i[127-8*INV_SRC -: 8];
`endif
    end
  end

endmodule

// File: rtl/inv_shift_rows_seq.sv
// Byte-serial AES InvShiftRows: collects 16 bytes, presents the permuted block one cycle after byte 15.
// Holds the block (in_ready=0) until out_ready; optional FWD_MODE_EN adds a per-block forward/inverse mode.
module inv_shift_rows_seq
  import aes_pkg::*;
#(
  parameter bit IN_MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
`ifdef FWD_MODE_EN
  input  logic         mode,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  isr_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  aes_state_t buf_q, buf_d;
  logic       accept;
  logic [3:0] byte_pos;

  // Byte position counted from the LSB end of the 128-bit buffer.
  assign byte_pos = IN_MSB_FIRST ? ~cnt_q : cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept = 1'b1;
          buf_d[{byte_pos, 3'b000} +: 8] = in_byte;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
    if (flush) begin
      state_d = ST_LOAD;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= 4'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

`ifdef FWD_MODE_EN
  logic mode_q;

  // Mode is latched with byte 0 so it stays fixed for the whole block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (accept && cnt_q == 4'd0) begin
      mode_q <= mode;
    end
  end

  inv_shift_map u_map (
    .mode_i  (mode_q),
    .state_i (buf_q),
    .state_o (out_state)
  );
`else
  inv_shift_map u_map (
    .state_i (buf_q),
    .state_o (out_state)
  );
`endif

endmodule

// File: tb/tb_inv_shift_rows_seq.sv
// Randomized and directed bench for inv_shift_rows_seq against a row-rotation reference model.
`timescale 1ns/1ps
module tb_inv_shift_rows_seq;

  localparam bit IN_MSB_FIRST = 1'b1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
`ifdef FWD_MODE_EN
  logic         mode;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inv_shift_rows_seq #(.IN_MSB_FIRST(IN_MSB_FIRST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
`ifdef FWD_MODE_EN
    .mode      (mode),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: gather each row, rotate it as a list, scatter back.
  function automatic logic [127:0] ref_shift(input logic [7:0] b [16], input bit fwd);
    logic [7:0]   s [16];
    logic [7:0]   row [$];
    logic [127:0] res;
    res = '0;
    for (int k = 0; k < 16; k++) s[k] = IN_MSB_FIRST ? b[k] : b[15-k];
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < 4; c++) row.push_back(s[r+4*c]);
      for (int n = 0; n < r; n++) begin
        if (fwd) row.push_back(row.pop_front());
        else     row.push_front(row.pop_back());
      end
      for (int c = 0; c < 4; c++) res[127-8*(r+4*c) -: 8] = row[c];
    end
    return res;
  endfunction

  task automatic to_blk(input logic [127:0] v, output logic [7:0] b [16]);
    for (int i = 0; i < 16; i++) b[i] = v[127-8*i -: 8];
  endtask

  task automatic rand_blk(output logic [7:0] b [16]);
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
  endtask

  task automatic load_bytes(input logic [7:0] b [16], input int n, input bit gaps, input bit fwd);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_byte  = 8'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_byte  = b[i];
`ifdef FWD_MODE_EN
      mode     = fwd;
`else
      if (fwd) $display("note: forward mode requested in inverse-only build");
`endif
      check_eq("load_rdy", 128'(in_ready), 128'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [127:0] exp, input int hold);
    check_eq("out_vld", 128'(out_valid), 128'd1);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_byte   = 8'($urandom);
      check_eq("hold_rdy", 128'(in_ready), 128'd0);
      check_eq("hold_vld", 128'(out_valid), 128'd1);
      check_eq("hold_dat", out_state, exp);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_byte   = 8'($urandom);
    check_eq("out_dat", out_state, exp);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("post_vld", 128'(out_valid), 128'd0);
    check_eq("post_rdy", 128'(in_ready), 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]   seq [16];
    logic [7:0]   blk [16];
    logic [7:0]   s0 [16];
    logic [7:0]   s1 [16];
    logic [127:0] got [2];
    int           t_out [2];
    int           p, t, n_out;
    bit           acc;
    localparam logic [127:0] SEQ_INV = 128'h000d0a07_04010e0b_0805020f_0c090603;
    localparam logic [127:0] SEQ_IN  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] FWD_OUT = 128'h00050a0f_04090e03_080d0207_0c01060b;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
`ifdef FWD_MODE_EN
    mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_rdy", 128'(in_ready), 128'd1);
    check_eq("rst_vld", 128'(out_valid), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_rdy", 128'(in_ready), 128'd1);
    check_eq("rel_vld", 128'(out_valid), 128'd0);

    to_blk(SEQ_IN, seq);
    load_bytes(seq, 16, 1'b0, 1'b0);
    drain(SEQ_INV, 0);

    to_blk(FWD_OUT, blk);
    load_bytes(blk, 16, 1'b0, 1'b0);
    drain(SEQ_IN, 0);

    load_bytes(seq, 16, 1'b0, 1'b0);
    drain(SEQ_INV, 10);
    load_bytes(seq, 16, 1'b1, 1'b0);
    drain(SEQ_INV, 0);

    // Continuous streaming: two blocks, outputs expected 17 cycles apart.
    rand_blk(s0);
    rand_blk(s1);
    p = 0; t = 0; n_out = 0;
    t_out[0] = 0; t_out[1] = 0; got[0] = '0; got[1] = '0;
    out_ready = 1'b1;
    while (n_out < 2 && t < 60) begin
      in_valid = (p < 32);
      in_byte  = (p < 16) ? s0[p] : (p < 32) ? s1[p-16] : 8'h00;
      if (out_valid) begin
        got[n_out]   = out_state;
        t_out[n_out] = t;
        n_out++;
      end
      acc = in_ready && in_valid;
      @(negedge clk);
      if (acc) p++;
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("tp_count", 128'(n_out), 128'd2);
    check_eq("tp_first", 128'(t_out[0]), 128'd16);
    check_eq("tp_gap", 128'(t_out[1] - t_out[0]), 128'd17);
    check_eq("tp_blk0", got[0], ref_shift(s0, 1'b0));
    check_eq("tp_blk1", got[1], ref_shift(s1, 1'b0));

    rand_blk(blk);
    load_bytes(blk, 7, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("fl7_vld", 128'(out_valid), 128'd0);
    check_eq("fl7_rdy", 128'(in_ready), 128'd1);
    load_bytes(seq, 16, 1'b0, 1'b0);
    drain(SEQ_INV, 0);

    load_bytes(seq, 15, 1'b0, 1'b0);
    in_valid = 1'b1; in_byte = seq[15]; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check_eq("fl15_vld", 128'(out_valid), 128'd0);
    check_eq("fl15_rdy", 128'(in_ready), 128'd1);
    @(negedge clk);
    check_eq("fl15_vld2", 128'(out_valid), 128'd0);
    rand_blk(blk);
    load_bytes(blk, 16, 1'b1, 1'b0);
    drain(ref_shift(blk, 1'b0), 1);

    load_bytes(seq, 16, 1'b0, 1'b0);
    check_eq("flh_pre", 128'(out_valid), 128'd1);
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b0;
    check_eq("flh_vld", 128'(out_valid), 128'd0);
    rand_blk(blk);
    load_bytes(blk, 16, 1'b0, 1'b0);
    drain(ref_shift(blk, 1'b0), 0);

    load_bytes(seq, 9, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rmid_vld", 128'(out_valid), 128'd0);
    check_eq("rmid_rdy", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rmid_rel", 128'(in_ready), 128'd1);
    rand_blk(blk);
    load_bytes(blk, 16, 1'b0, 1'b0);
    drain(ref_shift(blk, 1'b0), 0);

    load_bytes(seq, 16, 1'b0, 1'b0);
    check_eq("rhold_pre", 128'(out_valid), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rhold_vld", 128'(out_valid), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rhold_rdy", 128'(in_ready), 128'd1);
    check_eq("rhold_vld2", 128'(out_valid), 128'd0);
    load_bytes(seq, 16, 1'b1, 1'b0);
    drain(SEQ_INV, 0);

`ifdef FWD_MODE_EN
    load_bytes(seq, 16, 1'b0, 1'b1);
    drain(FWD_OUT, 0);
    load_bytes(seq, 16, 1'b0, 1'b0);
    drain(SEQ_INV, 0);
`endif

    for (int n = 0; n < 20; n++) begin
      rand_blk(blk);
      load_bytes(blk, 16, 1'b1, 1'b0);
      drain(ref_shift(blk, 1'b0), $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
